// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: controller state encoding and default width.
package gcd_pkg;

  localparam int unsigned DEFAULT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StBusy,
    StDeliver
  } state_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Request FIFO for operand pairs. Pointers carry one extra wrap bit so empty is a plain
// pointer compare; full comes from the registered occupancy count.
module gcd_req_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[AW-1:0]];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gcd_requester.sv
// Host-side initiator for the GCD unit go/done handshake. Buffers operand pairs, runs one
// job at a time on the GCD unit and returns results in order on a valid/ready stream.
// Optional BUSY watchdog with GCD unit reset: define GCD_REQ_TIMEOUT_EN.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int unsigned W              = DEFAULT_W,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned GO_CYCLES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic [W-1:0] gcd_x,
  output logic [W-1:0] gcd_y,
  output logic         go_i,
  input  logic         done,
  input  logic [W-1:0] gcd_d,
  output logic         gcd_rst,
  output logic         busy
);

  localparam int unsigned GW = $clog2(GO_CYCLES);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GO_CYCLES < 2 || TIMEOUT_CYCLES == 0)
  begin : g_bad_param
    $error("gcd_requester: illegal parameter combination");
  end

  state_t        state_q, state_d;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [2*W-1:0] fifo_rdata;
  logic [W-1:0]  gcd_x_q, gcd_y_q;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic [GW-1:0] go_cnt_q, go_cnt_d;
  logic          done_q, done_rise, timeout;

  gcd_req_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .wdata ({req_a, req_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A done level carried over from an earlier job must fall before it counts again.
  assign done_rise = done && !done_q;

`ifdef GCD_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  // Watchdog counts BUSY cycles and restarts from zero on every BUSY entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (state_q != StBusy) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == StBusy) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) && !done_rise;
  assign gcd_rst = timeout;
`else
  assign timeout = 1'b0;
  assign gcd_rst = 1'b0;
`endif

  // Next-state, FIFO pop and result selection.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    go_cnt_d   = go_cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        go_cnt_d = '0;
        // The GCD unit never terminates on a zero operand, so answer those locally.
        if (gcd_x_q == '0 && gcd_y_q == '0) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = StDeliver;
        end else if (gcd_x_q == '0 || gcd_y_q == '0) begin
          res_data_d = gcd_x_q | gcd_y_q;
          res_err_d  = 1'b0;
          state_d    = StDeliver;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (go_cnt_q == GW'(GO_CYCLES - 1)) state_d = StBusy;
        else go_cnt_d = go_cnt_q + 1'b1;
      end
      StBusy: begin
        if (done_rise) begin
          res_data_d = gcd_d;
          res_err_d  = 1'b0;
          state_d    = StDeliver;
        end else if (timeout) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = StDeliver;
        end
      end
      StDeliver: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      gcd_x_q    <= '0;
      gcd_y_q    <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      go_cnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      go_cnt_q   <= go_cnt_d;
      done_q     <= done;
      if (fifo_pop) begin
        gcd_x_q <= fifo_rdata[2*W-1:W];
        gcd_y_q <= fifo_rdata[W-1:0];
      end
    end
  end

  assign req_ready = !fifo_full;
  assign res_valid = (state_q == StDeliver);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign gcd_x     = gcd_x_q;
  assign gcd_y     = gcd_y_q;
  assign go_i      = (state_q == StIssue);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: behavioural GCD unit, result scoreboard and directed/random stimulus.
module tb_gcd_requester;

  localparam int W              = 8;
  localparam int DEPTH          = 4;
  localparam int GO_CYCLES      = 2;
  localparam int TIMEOUT_CYCLES = 1024;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_err;
  logic [W-1:0] gcd_x, gcd_y;
  logic         go_i;
  logic         done;
  logic [W-1:0] gcd_d;
  logic         gcd_rst;
  logic         busy;

  always #5 clk = ~clk;

  gcd_requester #(
    .W              (W),
    .DEPTH          (DEPTH),
    .GO_CYCLES      (GO_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .gcd_x     (gcd_x),
    .gcd_y     (gcd_y),
    .go_i      (go_i),
    .done      (done),
    .gcd_d     (gcd_d),
    .gcd_rst   (gcd_rst),
    .busy      (busy)
  );

  typedef struct {
    int data;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Expected result of one job from the arithmetic rules alone.
  function automatic exp_t ref_result(input int a, input int b);
    exp_t e;
    int   x = a;
    int   y = b;
    int   t;
    if (a == 0 && b == 0) begin
      e.data = 0;
      e.err  = 1;
    end else if (a == 0 || b == 0) begin
      e.data = a + b;
      e.err  = 0;
    end else begin
      while (y != 0) begin
        t = x % y;
        x = y;
        y = t;
      end
      e.data = x;
      e.err  = 0;
    end
    return e;
  endfunction

  // Behavioural GCD unit: drops done on go, raises it with the result after a random run.
  bit           hang = 1'b0;
  bit           m_busy;
  int           m_cnt;
  logic [W-1:0] m_res;
  exp_t         m_e;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      gcd_d  <= '0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (gcd_rst) begin
      done   <= 1'b0;
      gcd_d  <= '0;
      m_busy <= 1'b0;
    end else if (go_i) begin
      m_e     = ref_result(int'(gcd_x), int'(gcd_y));
      done   <= 1'b0;
      m_busy <= 1'b1;
      m_cnt  <= int'($urandom_range(0, 6));
      m_res  <= W'(m_e.data);
    end else if (m_busy && !hang) begin
      if (m_cnt == 0) begin
        done   <= 1'b1;
        gcd_d  <= m_res;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  bit           prev_valid, prev_ready, prev_done, expect_valid_next;
  logic [W-1:0] prev_data;
  logic         prev_err;
  int           go_len = 0;
  int           go_total = 0;
  int           rst_pulses = 0;
  exp_t         got_e;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid        = 1'b0;
      prev_done         = 1'b0;
      expect_valid_next = 1'b0;
      go_len            = 0;
    end else begin
      if (expect_valid_next) check("done_to_valid", int'(res_valid), 1);
      expect_valid_next = busy && !go_i && done && !prev_done;
      if (prev_valid && !prev_ready) begin
        check("hold_valid", int'(res_valid), 1);
        check("hold_data", int'(res_data), int'(prev_data));
        check("hold_err", int'(res_err), int'(prev_err));
      end
      if (res_valid && res_ready) begin
        check("result_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          got_e = exp_q.pop_front();
          check("res_data", int'(res_data), got_e.data);
          check("res_err", int'(res_err), got_e.err);
        end
      end
      if (go_i) begin
        go_len++;
        go_total++;
      end else if (go_len != 0) begin
        check("go_len", go_len, GO_CYCLES);
        go_len = 0;
      end
      if (gcd_rst) rst_pulses++;
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_data  = res_data;
      prev_err   = res_err;
      prev_done  = done;
    end
  end

  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input int a, input int b, input int ed, input int ee);
    int   waited = 0;
    exp_t e;
    req_a     = W'(a);
    req_b     = W'(b);
    req_valid = 1'b1;
    while (!req_ready && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("push_accept_bound", int'(req_ready), 1);
    @(posedge clk);
    if (waited < 3000) begin
      e.data = ed;
      e.err  = ee;
      exp_q.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic push_ref(input int a, input int b);
    exp_t e;
    e = ref_result(a, b);
    push(a, b, e.data, e.err);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_bound", int'(exp_q.size() == 0 && !busy), 1);
  endtask

  int g0, lat, a, b;

  initial begin
    // Reset state
    #12;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_err", int'(res_err), 0);
    check("rst_gcd_x", int'(gcd_x), 0);
    check("rst_gcd_y", int'(gcd_y), 0);
    check("rst_go_i", int'(go_i), 0);
    check("rst_gcd_rst", int'(gcd_rst), 0);
    check("rst_busy", int'(busy), 0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    // Normal job
    g0 = go_total;
    push(48, 18, 6, 0);
    wait_idle(200);
    check("go_cycles_48_18", go_total - g0, 2);

    // One zero operand: answered locally, pop to res_valid in 2 cycles
    g0  = go_total;
    push(7, 0, 7, 0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("zero_path_latency", lat, 2);
    wait_idle(200);
    check("no_go_7_0", go_total - g0, 0);

    // Both zero: error result
    g0 = go_total;
    push(0, 0, 0, 1);
    wait_idle(200);
    check("no_go_0_0", go_total - g0, 0);

    // Back-pressure fills the FIFO, then drains in order
    res_ready = 1'b0;
    push(12, 8, 4, 0);
    push(9, 6, 3, 0);
    push(35, 14, 7, 0);
    push(17, 5, 1, 0);
    push(100, 75, 25, 0);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("bp_req_ready_low", int'(req_ready), 0);
    check("bp_res_valid", int'(res_valid), 1);
    check("bp_res_head", int'(res_data), 4);
    res_ready = 1'b1;
    wait_idle(500);

    // Reset in the middle of BUSY with a full FIFO behind it
    hang = 1'b1;
    push(48, 18, 6, 0);
    push(1, 2, 1, 0);
    push(3, 4, 1, 0);
    push(5, 6, 1, 0);
    push(7, 8, 1, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", int'(busy && !go_i), 1);
    check("pre_rst_req_ready", int'(req_ready), 0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_go_i", int'(go_i), 0);
    check("mid_rst_res_valid", int'(res_valid), 0);
    check("mid_rst_req_ready", int'(req_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    exp_q.delete();
    hang = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

`ifdef GCD_REQ_TIMEOUT_EN
    // GCD unit never answers: watchdog recovers with an error result
    hang = 1'b1;
    g0   = rst_pulses;
    push(5, 3, 0, 1);
    wait_idle(TIMEOUT_CYCLES + 200);
    check("timeout_rst_pulses", rst_pulses - g0, 1);
    hang = 1'b0;
`endif

    // Randomized jobs with random result back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      push_ref(a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 10)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_idle(5000);
    rand_ready = 1'b0;
    res_ready  = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Host-side initiator for the GCD unit's go/done handshake. Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. For each pair it presents the operands to the GCD unit and pulses `go_i`, waits for `done`, and captures the result. Results are returned on a valid/ready output stream. Sits between the system bus glue and the GCD controller/datapath pair.

## Interface
Parameters:
- `W`, 8: operand/result width.
- `DEPTH`, 4: request FIFO depth; power of 2, ≥2.
- `GO_CYCLES`, 2: cycles `go_i` is held high per job; must be ≥2.
- `TIMEOUT_CYCLES`, 1024: BUSY watchdog limit; used only with `GCD_REQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  operand pair valid.
- `req_ready`  out  1  FIFO not full.
- `req_a`, `req_b`  in  W  operands.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumed.
- `res_data`  out  W  GCD result.
- `res_err`  out  1  invalid job (both operands zero, or timeout).
- `gcd_x`, `gcd_y`  out  W  operands to the GCD datapath.
- `go_i`  out  1  start request to the GCD controller.
- `done`  in  1  level completion flag from the GCD controller.
- `gcd_d`  in  W  GCD datapath result register.
- `gcd_rst`  out  1  one-cycle reset pulse to the GCD unit (timeout recovery).
- `busy`  out  1  FSM not in IDLE.

## Operation
- Push into the FIFO when `req_valid && req_ready`. Pop occurs only in IDLE with the FIFO non-empty, loading `gcd_x`/`gcd_y` from the head entry.
- States: IDLE, CHECK, ISSUE, BUSY, DELIVER.
  - IDLE: if the FIFO is non-empty, pop and go to CHECK.
  - CHECK, zero handling (the GCD unit never terminates on a zero operand):
    - both operands zero → `res_data`=0, `res_err`=1, go to DELIVER.
    - exactly one operand zero → `res_data` = the nonzero operand, `res_err`=0, go to DELIVER, no `go_i`.
    - otherwise → ISSUE.
  - ISSUE: `go_i`=1 for exactly `GO_CYCLES` cycles, then BUSY.
  - BUSY: `go_i`=0. Wait for a `done` rising edge (registered `done_q`=0, `done`=1). On the edge, capture `gcd_d` into `res_data`, set `res_err`=0, go to DELIVER. A `done` already high on entry (left over from a previous job) is ignored until it falls and rises again.
  - DELIVER: `res_valid`=1; on `res_ready` → IDLE.
- `gcd_x`/`gcd_y` are held stable from CHECK until leaving BUSY.
- Reset values: `req_ready`=1, `res_valid`=0, `res_data`=0, `res_err`=0, `gcd_x`=`gcd_y`=0, `go_i`=0, `gcd_rst`=0, `busy`=0, FIFO empty, `done_q`=0, state IDLE.
- Reset asserted mid-job aborts the job, drops `go_i` immediately, and empties the FIFO. The GCD unit must share `reset`.

## Timing
- `req_ready` is derived from the registered FIFO count. A push into a full FIFO is refused even if a pop happens in the same cycle.
- A push into an empty FIFO is popped no earlier than the next cycle.
- Zero-operand path latency: pop → `res_valid` in 2 cycles.
- Normal path latency: `GO_CYCLES` + GCD run time + 1 cycle (edge detect) + 1 cycle (DELIVER register).
- Results come out strictly in request order. Only one job is outstanding at a time.
- `res_valid` and `res_data` stay stable until `res_ready`; back-pressure stalls new pops.

## Configuration
- `GCD_REQ_TIMEOUT_EN` defined:
  - A counter runs while in BUSY.
  - When it reaches `TIMEOUT_CYCLES` without a `done` edge: `gcd_rst`=1 for one cycle, `res_data`=0, `res_err`=1, go to DELIVER.
  - The counter clears on entry to BUSY.
- `GCD_REQ_TIMEOUT_EN` undefined: no counter, `gcd_rst` tied to 0, BUSY waits indefinitely.

## Structure
- Shared package `gcd_pkg`: state encoding constants (IDLE, CHECK, ISSUE, BUSY, DELIVER) and the default `W`.
- One sub-module `gcd_req_fifo`: synchronous FIFO, width 2·W, depth `DEPTH`, with full/empty flags and a registered count. Pointers wrap modulo `DEPTH`, with an extra bit to distinguish full from empty.

## Test plan
- Push (48,18) with the GCD model attached → exactly 2 cycles of `go_i`, then `res_data`=6, `res_err`=0.
- Push (7,0) → `res_data`=7, `res_err`=0, `go_i` never asserted, `res_valid` 2 cycles after pop.
- Push (0,0) → `res_data`=0, `res_err`=1, no `go_i`.
- Hold `res_ready`=0 and push 5 pairs → `req_ready` low after the FIFO fills. Release `res_ready` → all results drain in order (e.g. (12,8)→4, (9,6)→3, (35,14)→7, (17,5)→1, (100,75)→25).
- Assert `reset` mid-BUSY → `go_i`=0, `res_valid`=0, `req_ready`=1 within the same cycle.
- With `GCD_REQ_TIMEOUT_EN`, the model never raises `done` → after 1024 BUSY cycles, one-cycle `gcd_rst` pulse, then `res_err`=1, `res_data`=0.
